rc4_decrypt_prga: RTL and testbench
===================================

# rc4_decrypt_prga

RC4 keystream-generation and decryption stage (PRGA phase), directly upstream of the message validity checker. After the key-scheduling stage has initialised the external 256-byte S RAM, this block:
- walks the RC4 pseudo-random generation loop over S,
- XORs each keystream byte with the matching encrypted-ROM byte,
- presents the plaintext as a register array with a level `decrypt_done` that the validity checker consumes.

## Interface
Parameters:
- `MSG_LEN`, 32: number of message bytes decrypted; range 1..32.
- `S_ADDR_W`, 8: S RAM address width (S depth 2^8 = 256).

Ports:
- `CLOCK_50`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; one clock, reset asynchronous active-high (fixed).
- `start`  in  1  level request from key controller; S RAM already KSA-initialised when high.
- `s_addr`  out  8  S RAM address.
- `s_wdata`  out  8  S RAM write data.
- `s_wren`  out  1  S RAM write enable.
- `s_rdata`  in  8  S RAM read data, valid one cycle after `s_addr` presented.
- `enc_addr`  out  5  encrypted ROM address (message index k).
- `enc_rdata`  in  8  encrypted ROM data, one-cycle read latency.
- `decrypted_data`  out  8 x 32 array  plaintext bytes `[31:0]`; entries >= `MSG_LEN` stay 0.
- `decrypt_done`  out  1  high while result valid; level, not pulse.

## Operation
- Algorithm per byte k = 0..MSG_LEN-1:
  - i = i+1
  - j = j+S[i]
  - swap S[i], S[j]
  - dec[k] = S[S[i]+S[j]] ^ enc[k]
- All index arithmetic is 8-bit, wrapping mod 256. k is 5-bit.
- States:
  - IDLE
  - RD_I: s_addr=i
  - LAT_I: si<=s_rdata; j<=j+s_rdata
  - RD_J: s_addr=j
  - LAT_J: sj<=s_rdata
  - WR_I: s_addr=i, s_wdata=sj, s_wren=1
  - WR_J: s_addr=j, s_wdata=si, s_wren=1
  - RD_F: s_addr=si+sj, enc_addr=k
  - LAT_F: decrypted_data[k]<=s_rdata^enc_rdata; i<=i+1; k<=k+1
  - DONE
- Transitions:
  - IDLE→RD_I when start=1. On that edge: i<=1, j<=0, k<=0, all decrypted_data cleared to 0.
  - LAT_F→RD_I if k<MSG_LEN-1.
  - LAT_F→DONE if k==MSG_LEN-1.
  - DONE→IDLE when start=0.
- In states not listed above, `s_addr` and `s_wdata` = 0, `s_wren` = 0, and `enc_addr` holds k.
- i==j: both writes hit the same address with the same value; S is unchanged, which is correct RC4.
- `start` dropping mid-run is ignored. The run completes, DONE is entered, and the block then returns to IDLE on the next edge.
- `start` high in DONE: the block holds DONE, so no re-run occurs until `start` has been low for at least one cycle.

## Timing
- Reset values: state=IDLE; i=j=k=si=sj=0; `s_addr`=0, `s_wdata`=0, `s_wren`=0, `enc_addr`=0; all `decrypted_data`=0; `decrypt_done`=0.
- Exactly 8 cycles per byte.
- `decrypt_done` goes high on the (8·MSG_LEN+1)-th rising edge after the edge that samples start=1. MSG_LEN=32 gives 257 edges.
- `decrypt_done` is high for at least one cycle. It falls on the first edge sampling start=0 while in DONE.
- `decrypted_data` is stable throughout DONE and until the next accepted start.
- Reset asserted mid-run: all state and outputs return to reset values immediately (asynchronously). Any partial S RAM writes already made are not undone.
- `s_wren` is asserted only in WR_I and WR_J: 2·MSG_LEN write cycles per run.

## Structure
- Shared package `rc4_pkg`:
  - `byte_t` (logic [7:0])
  - `prga_state_e` enum (10 states above)
  - `MSG_LEN_DEFAULT`=32
  - `S_DEPTH`=256
- Single module; no sub-module. S RAM and encrypted ROM are external and instantiated by the top level. The validity checker connects to `decrypted_data` and `decrypt_done`.

## Test plan
- Identity S (S[x]=x), enc ROM all 0x00, MSG_LEN=32:
  - `decrypted_data[0]`=0x02 (exercises i==j=1); remaining bytes match the bench reference model.
  - S RAM final contents match the model.
- Full RC4 vector, MSG_LEN=9: S preloaded with the KSA of key "Key", enc = BB F3 16 E8 D9 40 AF 0A D3 -> `decrypted_data[0..8]` = "Plaintext" (50 6C 61 69 6E 74 65 78 74).
- Latency, MSG_LEN=32, start high at edge 0:
  - `decrypt_done` rises at edge 257 exactly.
  - `s_wren` counted high for exactly 64 cycles.
  - start low at edge 300 -> `decrypt_done` 0 at edge 301.
- start pulsed high for one cycle only -> the run completes, `decrypt_done` is high for exactly one cycle, then IDLE.
- Reset asserted during byte 10 -> all outputs 0 immediately. start still high after release -> fresh run with `decrypted_data` cleared, done after 257 edges.
- start held high through DONE for 50 cycles -> no second run, `s_wren` stays 0, outputs stable.

Source files
------------

// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types and constants for the RC4 PRGA decrypt stage
package rc4_pkg;
    typedef logic [7:0] byte_t;
    typedef enum logic [3:0] {
        IDLE, RD_I, LAT_I, RD_J, LAT_J, WR_I, WR_J, RD_F, LAT_F, DONE
    } prga_state_e;
    localparam int MSG_LEN_DEFAULT = 32;
    localparam int S_DEPTH = 256;
endpackage

// File: rtl/rc4_decrypt_prga.sv
// rc4_decrypt_prga: RC4 keystream generation over external S RAM, XOR with encrypted ROM
//   CLOCK_50/reset          : clock, async active-high reset
//   start                   : level run request (S RAM already key-scheduled)
//   s_addr/s_wdata/s_wren   : S RAM port, s_rdata one cycle after s_addr
//   enc_addr/enc_rdata      : encrypted ROM port, one-cycle read latency
//   decrypted_data          : plaintext bytes, entries >= MSG_LEN stay 0
//   decrypt_done            : level, high while decrypted_data is valid
module rc4_decrypt_prga
    import rc4_pkg::*;
#(
    parameter int MSG_LEN  = MSG_LEN_DEFAULT,
    parameter int S_ADDR_W = 8
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                start,
    output logic [S_ADDR_W-1:0] s_addr,
    output byte_t               s_wdata,
    output logic                s_wren,
    input  byte_t               s_rdata,
    output logic [4:0]          enc_addr,
    input  byte_t               enc_rdata,
    output byte_t               decrypted_data [32],
    output logic                decrypt_done
);
    localparam logic [4:0] K_LAST = 5'(MSG_LEN - 1);

    prga_state_e state_q;
    byte_t       i_q, j_q, si_q, sj_q;
    logic [4:0]  k_q;
    byte_t       dec_q [32];
    logic        done_q, done_d;
    byte_t       f_idx, addr_sel;

    assign f_idx = si_q + sj_q;

    always_comb begin
        addr_sel = (state_q == RD_I || state_q == WR_I) ? i_q :
                   (state_q == RD_J || state_q == WR_J) ? j_q :
                   (state_q == RD_F)                    ? f_idx : 8'd0;
        s_addr   = S_ADDR_W'(addr_sel);
        s_wdata  = (state_q == WR_I) ? sj_q : (state_q == WR_J) ? si_q : 8'd0;
        s_wren   = (state_q == WR_I) || (state_q == WR_J);
        // Rises one edge after DONE is entered; the first edge that sees start low in DONE clears it
        done_d   = (state_q == DONE) && (start || !done_q);
    end

    assign enc_addr       = k_q;
    assign decrypted_data = dec_q;
    assign decrypt_done   = done_q;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            done_q  <= 1'b0;
            for (int n = 0; n < 32; n++) dec_q[n] <= '0;
        end else begin
            done_q <= done_d;
            case (state_q)
                IDLE: if (start) begin
                    state_q <= RD_I;
                    i_q     <= 8'd1;
                    j_q     <= '0;
                    k_q     <= '0;
                    for (int n = 0; n < 32; n++) dec_q[n] <= '0;
                end
                RD_I:  state_q <= LAT_I;
                LAT_I: begin
                    si_q    <= s_rdata;
                    j_q     <= j_q + s_rdata;
                    state_q <= RD_J;
                end
                RD_J:  state_q <= LAT_J;
                LAT_J: begin
                    sj_q    <= s_rdata;
                    state_q <= WR_I;
                end
                WR_I:  state_q <= WR_J;
                WR_J:  state_q <= RD_F;
                RD_F:  state_q <= LAT_F;
                LAT_F: begin
                    dec_q[k_q] <= s_rdata ^ enc_rdata;
                    i_q        <= i_q + 8'd1;
                    k_q        <= k_q + 5'd1;
                    state_q    <= (k_q == K_LAST) ? DONE : RD_I;
                end
                DONE:    if (!start) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rc4_decrypt_prga.sv
// tb_rc4_decrypt_prga: randomized self-checking bench against a behavioural RC4 model
module tb_rc4_decrypt_prga;
    import rc4_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic start_a = 1'b0, start_b = 1'b0;
    logic [7:0] s_addr_a, s_addr_b;
    byte_t s_wdata_a, s_wdata_b, s_rdata_a, s_rdata_b, enc_rdata_a, enc_rdata_b;
    logic s_wren_a, s_wren_b, done_a, done_b;
    logic [4:0] enc_addr_a, enc_addr_b;
    byte_t dec_a [32];
    byte_t dec_b [32];

    byte_t ram_a [256];
    byte_t rom_a [32];
    byte_t ram_b [256];
    byte_t rom_b [32];

    rc4_decrypt_prga #(.MSG_LEN(32)) dut_a (
        .CLOCK_50(clk), .reset(rst), .start(start_a),
        .s_addr(s_addr_a), .s_wdata(s_wdata_a), .s_wren(s_wren_a), .s_rdata(s_rdata_a),
        .enc_addr(enc_addr_a), .enc_rdata(enc_rdata_a),
        .decrypted_data(dec_a), .decrypt_done(done_a)
    );

    rc4_decrypt_prga #(.MSG_LEN(9)) dut_b (
        .CLOCK_50(clk), .reset(rst), .start(start_b),
        .s_addr(s_addr_b), .s_wdata(s_wdata_b), .s_wren(s_wren_b), .s_rdata(s_rdata_b),
        .enc_addr(enc_addr_b), .enc_rdata(enc_rdata_b),
        .decrypted_data(dec_b), .decrypt_done(done_b)
    );

    always @(posedge clk) begin
        if (s_wren_a) ram_a[s_addr_a] <= s_wdata_a;
        s_rdata_a   <= ram_a[s_addr_a];
        enc_rdata_a <= rom_a[enc_addr_a];
        if (s_wren_b) ram_b[s_addr_b] <= s_wdata_b;
        s_rdata_b   <= ram_b[s_addr_b];
        enc_rdata_b <= rom_b[enc_addr_b];
    end

    int checks = 0;
    int errors = 0;
    int wtot = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural RC4 PRGA: expected plaintext, final S and the ordered list of S writes
    byte_t ms [256];
    byte_t menc [32];
    byte_t exp_a [32];
    logic [15:0] wq_a [$];

    task automatic model_run(input int n);
        byte_t i, j, t, tmp;
        i = 0;
        j = 0;
        for (int k = 0; k < 32; k++) exp_a[k] = 8'h00;
        for (int k = 0; k < n; k++) begin
            i = i + 8'd1;
            j = j + ms[i];
            wq_a.push_back({i, ms[j]});
            wq_a.push_back({j, ms[i]});
            tmp = ms[i];
            ms[i] = ms[j];
            ms[j] = tmp;
            t = ms[i] + ms[j];
            exp_a[k] = ms[t] ^ menc[k];
        end
    endtask

    task automatic load_a(input bit identity, input bit zero_enc);
        byte_t p [256];
        byte_t tmp;
        int r;
        for (int x = 0; x < 256; x++) p[x] = 8'(x);
        if (!identity)
            for (int x = 255; x > 0; x--) begin
                r = int'($urandom_range(x, 0));
                tmp = p[x];
                p[x] = p[r];
                p[r] = tmp;
            end
        for (int x = 0; x < 256; x++) begin
            ram_a[x] <= p[x];
            ms[x] = p[x];
        end
        for (int k = 0; k < 32; k++) begin
            menc[k] = zero_enc ? 8'h00 : 8'($urandom);
            rom_a[k] <= menc[k];
        end
        wq_a.delete();
        model_run(32);
    endtask

    // Per-cycle compare: every S write must be the next one the model predicts; while done, plaintext must match
    always @(negedge clk) begin
        logic [15:0] w;
        int bad;
        if (!rst) begin
            if (s_wren_a) begin
                wtot++;
                if (wq_a.size() == 0) chk("unexpected_write", int'({s_addr_a, s_wdata_a}), -1);
                else begin
                    w = wq_a.pop_front();
                    chk("s_write", int'({s_addr_a, s_wdata_a}), int'(w));
                end
            end
            if (done_a) begin
                bad = 0;
                for (int k = 0; k < 32; k++) if (dec_a[k] !== exp_a[k]) bad++;
                chk("dec_vs_model", bad, 0);
            end
        end
    end

    task automatic measure_done(output int n);
        for (n = 0; n < 400; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_a) break;
        end
    endtask

    function automatic int s_mismatches();
        int bad = 0;
        for (int x = 0; x < 256; x++) if (ram_a[x] !== ms[x]) bad++;
        return bad;
    endfunction

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n, w0, bad, hi;
        byte_t snap [32];
        byte_t kb [256];
        byte_t key [3];
        byte_t ct [9];
        byte_t pt [9];
        byte_t j, tmp;
        key = '{8'h4B, 8'h65, 8'h79};
        ct  = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        pt  = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
        load_a(1'b1, 1'b1);
        for (int x = 0; x < 256; x++) kb[x] = 8'(x);
        j = 0;
        for (int x = 0; x < 256; x++) begin
            j = j + kb[x] + key[x % 3];
            tmp = kb[x];
            kb[x] = kb[j];
            kb[j] = tmp;
        end
        for (int x = 0; x < 256; x++) ram_b[x] <= kb[x];
        for (int k = 0; k < 32; k++) rom_b[k] <= (k < 9) ? ct[k] : 8'h00;
        #22;
        chk("rst_s_addr", int'(s_addr_a), 0);
        chk("rst_s_wdata", int'(s_wdata_a), 0);
        chk("rst_s_wren", int'(s_wren_a), 0);
        chk("rst_enc_addr", int'(enc_addr_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_dec0", int'(dec_a[0]), 0);
        @(negedge clk);
        rst = 1'b0;

        // Identity S, zero ciphertext, plus the known-answer vector on the 9-byte instance
        w0 = wtot;
        start_a = 1'b1;
        start_b = 1'b1;
        measure_done(n);
        chk("latency", n, 257);
        chk("identity_dec0", int'(dec_a[0]), 8'h02);
        chk("wren_count", wtot - w0, 64);
        chk("final_s", s_mismatches(), 0);
        for (int k = 0; k < 9; k++) chk($sformatf("plaintext_%0d", k), int'(dec_b[k]), int'(pt[k]));
        chk("b_tail_zero", int'(dec_b[9]), 0);
        chk("b_done", int'(done_b), 1);

        // start held through DONE: no rerun, outputs stable
        snap = dec_a;
        w0 = wtot;
        repeat (50) @(negedge clk);
        chk("hold_wren", wtot - w0, 0);
        chk("hold_done", int'(done_a), 1);
        bad = 0;
        for (int k = 0; k < 32; k++) if (dec_a[k] !== snap[k]) bad++;
        chk("hold_stable", bad, 0);
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge clk);
        chk("done_fall", int'(done_a), 0);

        // One-cycle start pulse with random S and ciphertext
        @(negedge clk);
        load_a(1'b0, 1'b0);
        @(negedge clk);
        w0 = wtot;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        hi = 0;
        repeat (300) @(negedge clk) if (done_a) hi++;
        chk("pulse_done_cycles", hi, 1);
        chk("pulse_wren_count", wtot - w0, 64);
        chk("pulse_final_s", s_mismatches(), 0);

        // Reset during byte 10, start kept high
        load_a(1'b0, 1'b0);
        @(negedge clk);
        start_a = 1'b1;
        repeat (85) @(negedge clk);
        chk("mid_wren_before_rst", int'(s_wren_a), 1);
        #2 rst = 1'b1;
        #1;
        chk("mrst_s_addr", int'(s_addr_a), 0);
        chk("mrst_s_wren", int'(s_wren_a), 0);
        chk("mrst_enc_addr", int'(enc_addr_a), 0);
        chk("mrst_done", int'(done_a), 0);
        bad = 0;
        for (int k = 0; k < 32; k++) if (dec_a[k] !== 8'h00) bad++;
        chk("mrst_dec_zero", bad, 0);
        wq_a.delete();
        @(negedge clk);
        for (int x = 0; x < 256; x++) ms[x] = ram_a[x];
        model_run(32);
        w0 = wtot;
        rst = 1'b0;
        measure_done(n);
        chk("rerun_latency", n, 257);
        chk("rerun_wren_count", wtot - w0, 64);
        chk("rerun_final_s", s_mismatches(), 0);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        chk("end_done", int'(done_a), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
